// File: rtl/exe_stage_pro.sv
// Execute stage: single-cycle ALU, iterative radix-2 divider, load/store address and store formatting.
// Defining EXE_FWD_EN adds the es_fwd_* bypass outputs for the decode stage.
module exe_stage_pro #(
    parameter  int DATA_W = 32,
    localparam int BE_W   = DATA_W / 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              flush,
    input  logic              ms_allowin,
    output logic              es_allowin,
    input  logic              ds_to_es_valid,
    input  logic [3:0]        ds_op,
    input  logic [DATA_W-1:0] ds_src1,
    input  logic [DATA_W-1:0] ds_src2,
    input  logic [DATA_W-1:0] ds_store_data,
    input  logic [31:0]       ds_pc,
    input  logic [4:0]        ds_dest,
    input  logic              ds_gr_we,
    input  logic              ds_mem_rd,
    input  logic              ds_mem_wr,
    input  logic [1:0]        ds_mem_size,
    input  logic              ds_mem_uns,
    output logic              es_to_ms_valid,
    output logic [DATA_W-1:0] es_result,
    output logic [31:0]       es_pc,
    output logic [4:0]        es_dest,
    output logic              es_gr_we,
    output logic              es_res_from_mem,
    output logic [1:0]        es_mem_size,
    output logic              es_mem_uns,
    output logic              es_ale,
`ifdef EXE_FWD_EN
    output logic              es_fwd_valid,
    output logic [4:0]        es_fwd_dest,
    output logic [DATA_W-1:0] es_fwd_data,
    output logic              es_fwd_block,
`endif
    output logic              data_sram_en,
    output logic [BE_W-1:0]   data_sram_we,
    output logic [DATA_W-1:0] data_sram_addr,
    output logic [DATA_W-1:0] data_sram_wdata
);
    localparam int SH_W  = $clog2(DATA_W);
    localparam int OFF_W = $clog2(BE_W);
    localparam int CNT_W = SH_W + 1;

    localparam logic [3:0] OP_ADD = 4'd0,  OP_SUB  = 4'd1,  OP_AND = 4'd2,  OP_OR   = 4'd3;
    localparam logic [3:0] OP_XOR = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU = 4'd6, OP_SLL  = 4'd7;
    localparam logic [3:0] OP_SRL = 4'd8,  OP_SRA  = 4'd9,  OP_DIV = 4'd10, OP_DIVU = 4'd11;
    localparam logic [3:0] OP_MOD = 4'd12, OP_MODU = 4'd13, OP_PASS2 = 4'd14;

    localparam logic [1:0] S_IDLE = 2'd0, S_RUN = 2'd1, S_DONE = 2'd2;

    logic              es_valid_q, es_valid_d;
    logic [3:0]        op_q, op_d;
    logic [DATA_W-1:0] src1_q, src1_d, src2_q, src2_d, st_data_q, st_data_d;
    logic [31:0]       pc_q, pc_d;
    logic [4:0]        dest_q, dest_d;
    logic              gr_we_q, gr_we_d, mem_rd_q, mem_rd_d, mem_wr_q, mem_wr_d, mem_uns_q, mem_uns_d;
    logic [1:0]        mem_size_q, mem_size_d;
    logic [1:0]        div_st_q, div_st_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] rem_q, rem_d, quo_q, quo_d;

    logic              es_ready_go, is_div, div_signed, a_neg, b_neg, is_mem, misalign, req_ok;
    logic [DATA_W-1:0] sum, a_mag, b_mag, alu_res, div_res, step_rem_in, step_quo_in;
    logic [DATA_W:0]   step_sh, step_trial;
    logic [DATA_W-1:0] step_rem, step_quo;
    logic [OFF_W-1:0]  align_mask;
    logic [BE_W-1:0]   be_base;

    assign is_div      = (op_q == OP_DIV) || (op_q == OP_DIVU) || (op_q == OP_MOD) || (op_q == OP_MODU);
    assign div_signed  = (op_q == OP_DIV) || (op_q == OP_MOD);
    assign es_ready_go = !is_div || (div_st_q == S_DONE);
    assign es_allowin  = !es_valid_q || (es_ready_go && ms_allowin);
    assign sum         = src1_q + src2_q;

    // Pipeline register: flush kills both the resident and the offered instruction.
    always_comb begin
        es_valid_d = es_valid_q;
        op_d       = op_q;
        src1_d     = src1_q;
        src2_d     = src2_q;
        st_data_d  = st_data_q;
        pc_d       = pc_q;
        dest_d     = dest_q;
        gr_we_d    = gr_we_q;
        mem_rd_d   = mem_rd_q;
        mem_wr_d   = mem_wr_q;
        mem_size_d = mem_size_q;
        mem_uns_d  = mem_uns_q;
        if (flush)
            es_valid_d = 1'b0;
        else if (es_allowin)
            es_valid_d = ds_to_es_valid;
        if (ds_to_es_valid && es_allowin && !flush) begin
            op_d       = ds_op;
            src1_d     = ds_src1;
            src2_d     = ds_src2;
            st_data_d  = ds_store_data;
            pc_d       = ds_pc;
            dest_d     = ds_dest;
            gr_we_d    = ds_gr_we;
            mem_rd_d   = ds_mem_rd;
            mem_wr_d   = ds_mem_wr;
            mem_size_d = ds_mem_size;
            mem_uns_d  = ds_mem_uns;
        end
    end

    always_comb begin
        alu_res = sum;
        case (op_q)
            OP_SUB:   alu_res = src1_q - src2_q;
            OP_AND:   alu_res = src1_q & src2_q;
            OP_OR:    alu_res = src1_q | src2_q;
            OP_XOR:   alu_res = src1_q ^ src2_q;
            OP_SLT:   alu_res = {{(DATA_W-1){1'b0}}, $signed(src1_q) < $signed(src2_q)};
            OP_SLTU:  alu_res = {{(DATA_W-1){1'b0}}, src1_q < src2_q};
            OP_SLL:   alu_res = src1_q << src2_q[SH_W-1:0];
            OP_SRL:   alu_res = src1_q >> src2_q[SH_W-1:0];
            OP_SRA:   alu_res = $signed(src1_q) >>> src2_q[SH_W-1:0];
            OP_PASS2: alu_res = src2_q;
            default:  alu_res = sum;
        endcase
    end

    // Divider works on magnitudes; the IDLE cycle already retires the first quotient bit.
    assign a_neg       = div_signed && src1_q[DATA_W-1];
    assign b_neg       = div_signed && src2_q[DATA_W-1];
    assign a_mag       = a_neg ? -src1_q : src1_q;
    assign b_mag       = b_neg ? -src2_q : src2_q;
    assign step_rem_in = (div_st_q == S_IDLE) ? '0 : rem_q;
    assign step_quo_in = (div_st_q == S_IDLE) ? a_mag : quo_q;
    assign step_sh     = {step_rem_in, step_quo_in[DATA_W-1]};
    assign step_trial  = step_sh - {1'b0, b_mag};
    assign step_rem    = step_trial[DATA_W] ? step_sh[DATA_W-1:0] : step_trial[DATA_W-1:0];
    assign step_quo    = {step_quo_in[DATA_W-2:0], !step_trial[DATA_W]};

    always_comb begin
        div_st_d = div_st_q;
        cnt_d    = cnt_q;
        rem_d    = rem_q;
        quo_d    = quo_q;
        case (div_st_q)
            S_IDLE: if (es_valid_q && is_div) begin
                div_st_d = S_RUN;
                cnt_d    = CNT_W'(DATA_W);
                rem_d    = step_rem;
                quo_d    = step_quo;
            end
            S_RUN: begin
                rem_d = step_rem;
                quo_d = step_quo;
                cnt_d = cnt_q - 1'b1;
                if (cnt_d == CNT_W'(1))
                    div_st_d = S_DONE;
            end
            S_DONE: if (es_valid_q && ms_allowin) div_st_d = S_IDLE;
            default: div_st_d = S_IDLE;
        endcase
        if (flush) begin
            div_st_d = S_IDLE;
            cnt_d    = '0;
        end
    end

    always_comb begin
        if (src2_q == '0)
            div_res = ((op_q == OP_DIV) || (op_q == OP_DIVU)) ? '1 : src1_q;
        else if ((op_q == OP_DIV) || (op_q == OP_DIVU))
            div_res = (a_neg ^ b_neg) ? -quo_q : quo_q;
        else
            div_res = a_neg ? -rem_q : rem_q;
    end

    assign is_mem = mem_rd_q || mem_wr_q;

    always_comb begin
        case (mem_size_q)
            2'd0:    begin align_mask = OFF_W'(0); be_base = BE_W'(1);  end
            2'd1:    begin align_mask = OFF_W'(1); be_base = BE_W'(3);  end
            2'd2:    begin align_mask = OFF_W'(3); be_base = BE_W'(15); end
            default: begin align_mask = OFF_W'(7); be_base = '1;        end
        endcase
        case (mem_size_q)
            2'd0:    data_sram_wdata = {BE_W{st_data_q[7:0]}};
            2'd1:    data_sram_wdata = {(BE_W/2){st_data_q[15:0]}};
            2'd2:    data_sram_wdata = {(BE_W/4){st_data_q[31:0]}};
            default: data_sram_wdata = st_data_q;
        endcase
    end

    assign misalign        = |(sum[OFF_W-1:0] & align_mask);
    assign es_ale          = es_valid_q && is_mem && misalign;
    assign req_ok          = es_valid_q && es_ready_go && ms_allowin && is_mem && !misalign && !flush;
    assign data_sram_en    = req_ok;
    assign data_sram_we    = (req_ok && mem_wr_q) ? (be_base << sum[OFF_W-1:0]) : '0;
    assign data_sram_addr  = sum;
    assign es_result       = is_mem ? sum : (is_div ? div_res : alu_res);
    assign es_to_ms_valid  = es_valid_q && es_ready_go && !flush;
    assign es_pc           = pc_q;
    assign es_dest         = dest_q;
    assign es_gr_we        = gr_we_q;
    assign es_res_from_mem = mem_rd_q;
    assign es_mem_size     = mem_size_q;
    assign es_mem_uns      = mem_uns_q;

`ifdef EXE_FWD_EN
    assign es_fwd_valid = es_valid_q && gr_we_q && (dest_q != 5'd0);
    assign es_fwd_dest  = dest_q;
    assign es_fwd_data  = es_result;
    assign es_fwd_block = es_valid_q && (mem_rd_q || (is_div && (div_st_q != S_DONE)));
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            es_valid_q <= 1'b0;
            op_q       <= '0;
            src1_q     <= '0;
            src2_q     <= '0;
            st_data_q  <= '0;
            pc_q       <= '0;
            dest_q     <= '0;
            gr_we_q    <= 1'b0;
            mem_rd_q   <= 1'b0;
            mem_wr_q   <= 1'b0;
            mem_size_q <= '0;
            mem_uns_q  <= 1'b0;
            div_st_q   <= S_IDLE;
            cnt_q      <= '0;
            rem_q      <= '0;
            quo_q      <= '0;
        end else begin
            es_valid_q <= es_valid_d;
            op_q       <= op_d;
            src1_q     <= src1_d;
            src2_q     <= src2_d;
            st_data_q  <= st_data_d;
            pc_q       <= pc_d;
            dest_q     <= dest_d;
            gr_we_q    <= gr_we_d;
            mem_rd_q   <= mem_rd_d;
            mem_wr_q   <= mem_wr_d;
            mem_size_q <= mem_size_d;
            mem_uns_q  <= mem_uns_d;
            div_st_q   <= div_st_d;
            cnt_q      <= cnt_d;
            rem_q      <= rem_d;
            quo_q      <= quo_d;
        end
    end
endmodule
